// File: rtl/wta_pkg.sv
// Shared constants for the winner-take-all search sequencer: FSM state encodings,
// datapath defaults and the channel-index width helper.
package wta_pkg;

  localparam int unsigned NChDefault = 8;
  localparam int unsigned PwWDefault = 12;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StLoad   = 3'd1;
  localparam state_t StArm    = 3'd2;
  localparam state_t StRun    = 3'd3;
  localparam state_t StSettle = 3'd4;
  localparam state_t StDone   = 3'd5;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wta_prio_enc.sv
// Lowest-index-first priority encoder: returns the lowest set bit position of vec_i
// and whether any bit is set.
module wta_prio_enc #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IW'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wta_search_seq.sv
// Sequences one winner-take-all search: latches the query onto the PWM bank, triggers it,
// tracks channel falls and captures the first-fall and k-NN results.
module wta_search_seq
  import wta_pkg::*;
#(
  parameter int unsigned N_CH    = NChDefault,
  parameter int unsigned PW_W    = PwWDefault,
  parameter int unsigned TIMEOUT = 5000,
  parameter int unsigned SETTLE  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [N_CH*PW_W-1:0]      i_query,
  output logic [N_CH*PW_W-1:0]      o_pulse_width,
  output logic                      o_pwm_tri,
  input  logic [N_CH-1:0]           i_fall,
  input  logic [N_CH-1:0]           i_nn,
  input  logic [N_CH-1:0]           i_knn,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [N_CH-1:0]           o_nn,
  output logic [N_CH-1:0]           o_knn,
  output logic [idx_w(N_CH)-1:0]    o_first_idx,
  output logic [PW_W:0]             o_first_time,
  output logic                      o_timeout
);

  localparam int unsigned IW = idx_w(N_CH);
  localparam int unsigned CW = PW_W + 1;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CntMax  = '1;
  localparam logic [SW-1:0] SetLast = SW'(SETTLE - 1);

  state_t                 state_q, state_d;
  logic [N_CH*PW_W-1:0]   pw_q, pw_d;
  logic [N_CH-1:0]        active_q, active_d;
  logic [N_CH-1:0]        fallen_q, fallen_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          set_q, set_d;
  logic [N_CH-1:0]        nn_q, nn_d;
  logic [N_CH-1:0]        knn_q, knn_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          time_q, time_d;
  logic                   seen_q, seen_d;
  logic                   tmo_q, tmo_d;

  logic [N_CH-1:0]        hit;
  logic [N_CH-1:0]        fallen_run;
  logic                   complete;
  logic [IW-1:0]          hit_idx;
  logic                   hit_vld;

  assign hit        = i_fall & active_q;
  assign fallen_run = fallen_q | hit;
  assign complete   = (fallen_run == active_q);

  wta_prio_enc #(
    .N  (N_CH),
    .IW (IW)
  ) u_prio_enc (
    .vec_i (hit),
    .idx_o (hit_idx),
    .vld_o (hit_vld)
  );

  always_comb begin
    state_d  = state_q;
    pw_d     = pw_q;
    active_d = active_q;
    fallen_d = fallen_q;
    cnt_d    = cnt_q;
    set_d    = set_q;
    nn_d     = nn_q;
    knn_d    = knn_q;
    idx_d    = idx_q;
    time_d   = time_q;
    seen_d   = seen_q;
    tmo_d    = tmo_q;

    // Abort pre-empts every capture so the previous results survive untouched.
    if (i_abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_start) begin
            state_d = StLoad;
            tmo_d   = 1'b0;
            idx_d   = '0;
            time_d  = '0;
            seen_d  = 1'b0;
          end
        end
        StLoad: begin
          pw_d     = i_query;
          fallen_d = '0;
          for (int i = 0; i < N_CH; i++) begin
            active_d[i] = |i_query[i*PW_W +: PW_W];
          end
          state_d = StArm;
        end
        StArm: begin
          cnt_d   = '0;
          state_d = StRun;
        end
        StRun: begin
          fallen_d = fallen_run;
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (hit_vld && !seen_q) begin
            seen_d = 1'b1;
            idx_d  = hit_idx;
            time_d = cnt_q;
          end
          // Completion takes precedence over a coincident timeout.
          if (complete) begin
            state_d = StSettle;
            set_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StSettle;
            set_d   = '0;
            tmo_d   = 1'b1;
          end
        end
        StSettle: begin
          if (set_q == SetLast) begin
            state_d = StDone;
            nn_d    = i_nn;
            knn_d   = i_knn;
          end else begin
            set_d = set_q + SW'(1);
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pw_q     <= '0;
      active_q <= '0;
      fallen_q <= '0;
      cnt_q    <= '0;
      set_q    <= '0;
      nn_q     <= '0;
      knn_q    <= '0;
      idx_q    <= '0;
      time_q   <= '0;
      seen_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pw_q     <= pw_d;
      active_q <= active_d;
      fallen_q <= fallen_d;
      cnt_q    <= cnt_d;
      set_q    <= set_d;
      nn_q     <= nn_d;
      knn_q    <= knn_d;
      idx_q    <= idx_d;
      time_q   <= time_d;
      seen_q   <= seen_d;
      tmo_q    <= tmo_d;
    end
  end

  assign o_pulse_width = pw_q;
  assign o_pwm_tri     = (state_q == StArm);
  assign o_busy        = (state_q != StIdle);
  assign o_done        = (state_q == StDone);
  assign o_nn          = nn_q;
  assign o_knn         = knn_q;
  assign o_first_idx   = idx_q;
  assign o_first_time  = time_q;
  assign o_timeout     = tmo_q;

endmodule

// File: tb/tb_wta_search_seq.sv
// Directed bench for wta_search_seq: scripted searches with hand-computed first-fall,
// latency, timeout, abort and reset expectations.
module tb_wta_search_seq;

  localparam int unsigned NCh = 8;
  localparam int unsigned PwW = 12;
  localparam int unsigned Tmo = 100;
  localparam int unsigned Stl = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_start;
  logic                 i_abort;
  logic [NCh*PwW-1:0]   i_query;
  logic [NCh*PwW-1:0]   o_pulse_width;
  logic                 o_pwm_tri;
  logic [NCh-1:0]       i_fall;
  logic [NCh-1:0]       i_nn;
  logic [NCh-1:0]       i_knn;
  logic                 o_busy;
  logic                 o_done;
  logic [NCh-1:0]       o_nn;
  logic [NCh-1:0]       o_knn;
  logic [2:0]           o_first_idx;
  logic [PwW:0]         o_first_time;
  logic                 o_timeout;

  wta_search_seq #(
    .N_CH    (NCh),
    .PW_W    (PwW),
    .TIMEOUT (Tmo),
    .SETTLE  (Stl)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_query       (i_query),
    .o_pulse_width (o_pulse_width),
    .o_pwm_tri     (o_pwm_tri),
    .i_fall        (i_fall),
    .i_nn          (i_nn),
    .i_knn         (i_knn),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_nn          (o_nn),
    .o_knn         (o_knn),
    .o_first_idx   (o_first_idx),
    .o_first_time  (o_first_time),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts trigger/done pulses and snapshots results during done.
  int         tri_cnt = 0;
  int         done_cnt = 0;
  int         tri_cyc = 0;
  int         done_cyc = 0;
  logic [2:0] d_idx = '0;
  logic [PwW:0] d_time = '0;
  logic       d_tmo = 1'b0;
  logic [7:0] d_nn = '0;
  logic [7:0] d_knn = '0;

  always @(negedge clk) begin
    if (o_pwm_tri) begin
      tri_cnt <= tri_cnt + 1;
      tri_cyc <= cyc;
    end
    if (o_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      d_idx    <= o_first_idx;
      d_time   <= o_first_time;
      d_tmo    <= o_timeout;
      d_nn     <= o_nn;
      d_knn    <= o_knn;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  int         fall_at [8];
  int         junk_at;
  logic [7:0] junk_mask;
  int         abort_at;
  int         start_cyc;
  int         end_cyc;
  int         tri_base;
  int         done_base;
  logic [95:0] q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] mk_q(input int base, input int stp);
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*12 +: 12] = 12'(base + stp * i);
    return r;
  endfunction

  function automatic logic [7:0] sched(input int c);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (fall_at[i] == c) m[i] = 1'b1;
    if (junk_at == c) m = m | junk_mask;
    return m;
  endfunction

  // Start in cycle t, drive the fall schedule against RUN cycle numbers, stop at IDLE.
  task automatic run_search(input string tag, input logic [95:0] qv, input logic [7:0] nn,
                            input logic [7:0] knn);
    int c;
    tri_base  = tri_cnt;
    done_base = done_cnt;
    i_query   = qv;
    i_nn      = nn;
    i_knn     = knn;
    i_start   = 1'b1;
    start_cyc = cyc;
    step();
    i_start = 1'b0;
    step();
    i_query = ~qv;
    c = 0;
    while (c < 400) begin
      step();
      if (!o_busy) break;
      i_fall  = sched(c);
      i_abort = (c == abort_at);
      c++;
    end
    i_fall  = '0;
    i_abort = 1'b0;
    end_cyc = cyc;
    chk({tag, "_idle"}, o_busy, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    i_start   = 1'b0;
    i_abort   = 1'b0;
    i_query   = '0;
    i_fall    = '0;
    i_nn      = '0;
    i_knn     = '0;
    junk_at   = -1;
    junk_mask = '0;
    abort_at  = -1;
    step();
    step();
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_pw", o_pulse_width, '0);
    chk("rst_misc", {o_done, o_pwm_tri, o_timeout, o_first_idx, o_first_time, o_nn, o_knn}, '0);
    rst = 1'b0;
    step();

    // 1: staggered falls, ch0 earliest at 10, last at 80 -> R=81
    fall_at = '{10, 20, 30, 40, 50, 60, 70, 80};
    q = mk_q(10, 10);
    run_search("t1", q, 8'h01, 8'h07);
    chk("t1_done_cnt", done_cnt - done_base, 1);
    chk("t1_tri_lat", tri_cyc - start_cyc, 2);
    chk("t1_done_lat", done_cyc - start_cyc, 86);
    chk("t1_idx", d_idx, 3'd0);
    chk("t1_time", d_time, 13'd10);
    chk("t1_tmo", d_tmo, 1'b0);
    chk("t1_nn", d_nn, 8'h01);
    chk("t1_knn", d_knn, 8'h07);
    chk("t1_pw", o_pulse_width, q);

    // 2: ch3 and ch5 tie at 7, last fall at 20 -> R=21
    fall_at = '{12, 15, 20, 7, 8, 7, 9, 11};
    q = mk_q(50, 0);
    run_search("t2", q, 8'h28, 8'h38);
    chk("t2_idx", d_idx, 3'd3);
    chk("t2_time", d_time, 13'd7);
    chk("t2_tmo", d_tmo, 1'b0);
    chk("t2_done_lat", done_cyc - start_cyc, 26);
    chk("t2_knn", d_knn, 8'h38);

    // 3: ch6 never falls -> leaves RUN at counter 99 (R=100)
    fall_at = '{5, 5, 5, 5, 5, 5, -1, 5};
    run_search("t3", q, 8'h01, 8'h01);
    chk("t3_done_cnt", done_cnt - done_base, 1);
    chk("t3_tmo", d_tmo, 1'b1);
    chk("t3_done_lat", done_cyc - start_cyc, 105);
    chk("t3_time", d_time, 13'd5);

    // 4: ch0/ch1 inactive, junk falls on them at cycle 2 must not count
    fall_at   = '{-1, -1, 4, 5, 6, 7, 8, 9};
    junk_at   = 2;
    junk_mask = 8'h03;
    q = mk_q(30, 0);
    q[23:0] = '0;
    run_search("t4", q, 8'h04, 8'h1C);
    junk_at = -1;
    chk("t4_idx", d_idx, 3'd2);
    chk("t4_time", d_time, 13'd4);
    chk("t4_tmo", d_tmo, 1'b0);
    chk("t4_done_lat", done_cyc - start_cyc, 15);

    // 5: abort in RUN cycle 5 -> IDLE at t+9, results from test 4 retained
    fall_at  = '{-1, -1, -1, -1, -1, -1, -1, -1};
    abort_at = 5;
    q = mk_q(40, 0);
    run_search("t5", q, 8'hFF, 8'hFF);
    abort_at = -1;
    chk("t5_abort_lat", end_cyc - start_cyc, 9);
    chk("t5_no_done", done_cnt - done_base, 0);
    chk("t5_nn_hold", o_nn, 8'h04);
    chk("t5_knn_hold", o_knn, 8'h1C);
    chk("t5_pw_hold", o_pulse_width, q);
    chk("t5_time_clr", o_first_time, 13'd0);
    fall_at = '{3, 3, 3, 3, 3, 3, 3, 3};
    run_search("t5b", q, 8'h80, 8'hE0);
    chk("t5b_done_cnt", done_cnt - done_base, 1);
    chk("t5b_done_lat", done_cyc - start_cyc, 9);
    chk("t5b_nn", d_nn, 8'h80);
    chk("t5b_time", d_time, 13'd3);

    // 6: start held high; only ch2 active, fall held -> two searches, rst in 2nd SETTLE
    tri_base  = tri_cnt;
    done_base = done_cnt;
    q = '0;
    q[35:24] = 12'd9;
    i_query = q;
    i_fall  = 8'h04;
    i_nn    = 8'hA5;
    i_knn   = 8'h5A;
    i_start = 1'b1;
    for (int k = 0; k < 11; k++) step();
    chk("t6_busy", o_busy, 1'b1);
    chk("t6_tri_cnt", tri_cnt - tri_base, 2);
    chk("t6_done_cnt", done_cnt - done_base, 1);
    chk("t6_nn", o_nn, 8'hA5);
    chk("t6_idx", o_first_idx, 3'd2);
    rst     = 1'b1;
    i_start = 1'b0;
    i_fall  = '0;
    step();
    chk("t6_rst_busy", o_busy, 1'b0);
    chk("t6_rst_pw", o_pulse_width, '0);
    chk("t6_rst_misc", {o_done, o_pwm_tri, o_timeout, o_first_idx, o_first_time, o_nn, o_knn},
        '0);
    rst = 1'b0;
    step();
    chk("t6_idle", o_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
